// File: rtl/mips_avalon_pkg.sv
// Shared types for the MIPS Avalon bus arbiter.
// State encoding, latched request bundle and bus constants.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE,
    FAULT
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } avalon_req_t;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [31:0] a);
    return (a[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mips_avalon_arbiter.sv
// Fixed-priority merge of instruction and data ports onto one
// Avalon-MM master, with sticky fault on misalignment or stall timeout.
module mips_avalon_arbiter
  import mips_avalon_pkg::*;
#(
  parameter bit          DATA_PRIORITY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        fault
);

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  state_t      state, state_n;
  avalon_req_t cur, cur_n, pick;
  logic        data_win, data_win_n;
  logic        pick_d;
  logic [31:0] wd_cnt;
  logic        wd_expire;
  logic        enter_bus;
  logic        capture;

  assign pick_d = d_req && (DATA_PRIORITY || !i_req);

  always_comb begin
    if (pick_d) begin
      pick.addr  = d_addr;
      pick.wdata = d_wdata;
      pick.be    = d_we ? d_be : BE_WORD;
      pick.we    = d_we;
    end else begin
      pick.addr  = i_addr;
      pick.wdata = '0;
      pick.be    = BE_WORD;
      pick.we    = 1'b0;
    end
  end

  assign wd_expire = (TMO != '0) && waitrequest
                  && (wd_cnt == TMO - 32'd1);

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    data_win_n = data_win;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          if (!is_aligned(pick.addr)) begin
            state_n = FAULT;
          end else begin
            state_n    = BUS;
            cur_n      = pick;
            data_win_n = pick_d;
          end
        end
      end
      BUS: begin
        // Completion wins over a watchdog hit in the same cycle.
        if (!waitrequest) state_n = DONE;
        else if (wd_expire) state_n = FAULT;
      end
      DONE:    state_n = IDLE;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  assign enter_bus = (state == IDLE) && (state_n == BUS);
  assign capture   = (state == BUS) && !waitrequest && !cur.we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur      <= '0;
      data_win <= 1'b0;
      wd_cnt   <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      data_win <= data_win_n;
      if (enter_bus) wd_cnt <= '0;
      else if (state == BUS && waitrequest) wd_cnt <= wd_cnt + 32'd1;
      if (capture) begin
        if (data_win) d_rdata <= readdata;
        else i_rdata <= readdata;
      end
    end
  end

  assign address    = cur.addr;
  assign writedata  = cur.wdata;
  assign byteenable = cur.be;
  assign read       = (state == BUS) && !cur.we;
  assign write      = (state == BUS) && cur.we;
  assign i_ack      = (state == DONE) && !data_win;
  assign d_ack      = (state == DONE) && data_win;
  assign fault      = (state == FAULT);

endmodule
